// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer and the blocks around it.
//  - S_IDLE / S_SHIFT : 2-bit FSM state encodings.
//  - DEFAULT_WIDTH    : default word width.
//  - IDLE_LEVEL       : line level while no word is in flight.
package bit_serializer_pkg;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_SHIFT = 2'b01;

  localparam int         DEFAULT_WIDTH = 8;
  localparam logic       IDLE_LEVEL    = 1'b1;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-in/serial-out stage. Words arrive on a valid/ready handshake and
// leave one bit per clock on dout. A one-entry holding buffer lets a second
// word be accepted while the first is shifting, so back-to-back words stream
// with no idle gap. The line idles at IDLE_BIT when no word is in flight.
//
// Ports:
//  clk          in   single clock, all state updates on posedge
//  reset        in   synchronous, active-high
//  load_data    in   WIDTH-bit word to serialize
//  load_valid   in   load_data is valid
//  load_ready   out  block can accept a word this cycle
//  dout         out  serial bit
//  dout_valid   out  dout carries a data bit
//  frame_start  out  dout carries the first bit of a word
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int   WIDTH     = DEFAULT_WIDTH,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = IDLE_LEVEL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start
);

  localparam int             CW        = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST      = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] IDLE_WORD = {WIDTH{IDLE_BIT}};

  logic [1:0]       state_reg,     state_next;
  logic [CW-1:0]    bit_cnt_reg,   bit_cnt_next;
  logic             hold_full_reg, hold_full_next;
  logic [WIDTH-1:0] hold_reg,      hold_next;
  logic [WIDTH-1:0] shifter_reg,   shifter_next;
  logic [WIDTH-1:0] shifted;
  logic             accept;

  // Reset gates ready so nothing is accepted on a reset edge.
  assign load_ready = !hold_full_reg && !reset;
  assign accept     = load_valid && load_ready;

  // The output end of the shifter depends on bit order; vacated positions
  // refill with IDLE_BIT so an exhausted register already holds idle level.
  generate
    if (MSB_FIRST) begin : g_msb
      assign dout    = shifter_reg[WIDTH-1];
      assign shifted = {shifter_reg[WIDTH-2:0], IDLE_BIT};
    end else begin : g_lsb
      assign dout    = shifter_reg[0];
      assign shifted = {IDLE_BIT, shifter_reg[WIDTH-1:1]};
    end
  endgenerate

  assign dout_valid  = (state_reg == S_SHIFT);
  assign frame_start = (state_reg == S_SHIFT) && (bit_cnt_reg == '0);

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    hold_full_next = hold_full_reg;
    hold_next      = hold_reg;
    shifter_next   = shifter_reg;
    case (state_reg)
      S_IDLE: begin
        // Empty pipeline: new word bypasses the hold buffer.
        if (accept) begin
          shifter_next = load_data;
          bit_cnt_next = '0;
          state_next   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_cnt_reg == LAST) begin
          if (hold_full_reg) begin
            // ready is low here, so no accept can collide with the reload.
            shifter_next   = hold_reg;
            hold_full_next = 1'b0;
            bit_cnt_next   = '0;
          end else if (accept) begin
            // Word arrives exactly on the last bit: bypass, no gap.
            shifter_next = load_data;
            bit_cnt_next = '0;
          end else begin
            state_next   = S_IDLE;
            shifter_next = IDLE_WORD;
            bit_cnt_next = '0;
          end
        end else begin
          shifter_next = shifted;
          bit_cnt_next = bit_cnt_reg + CW'(1);
          if (accept) begin
            hold_next      = load_data;
            hold_full_next = 1'b1;
          end
        end
      end
      default: begin
        // Unreachable encoding: recover to a clean idle line.
        state_next     = S_IDLE;
        hold_full_next = 1'b0;
        bit_cnt_next   = '0;
        shifter_next   = IDLE_WORD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      bit_cnt_reg   <= '0;
      hold_full_reg <= 1'b0;
      hold_reg      <= '0;
      shifter_reg   <= IDLE_WORD;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      hold_full_reg <= hold_full_next;
      hold_reg      <= hold_next;
      shifter_reg   <= shifter_next;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] load_data, load_data2;
  logic       load_valid, load_valid2;
  logic       load_ready, load_ready2;
  logic       dout, dout2;
  logic       dout_valid, dout_valid2;
  logic       frame_start, frame_start2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_msb (
    .clk(clk), .reset(reset),
    .load_data(load_data), .load_valid(load_valid), .load_ready(load_ready),
    .dout(dout), .dout_valid(dout_valid), .frame_start(frame_start)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
    .clk(clk), .reset(reset),
    .load_data(load_data2), .load_valid(load_valid2), .load_ready(load_ready2),
    .dout(dout2), .dout_valid(dout_valid2), .frame_start(frame_start2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] seq;
    logic [7:0]  w;
    logic [2:0]  hist;
    int          pulses;

    // 1: reset held two cycles with load_valid high
    reset = 1'b1; load_valid = 1'b1; load_data = 8'hFF;
    load_valid2 = 1'b0; load_data2 = 8'h00;
    step(); step();
    chk("rst_ready", load_ready, 1'b0);
    chk("rst_dout", dout, 1'b1);
    chk("rst_dvalid", dout_valid, 1'b0);
    chk("rst_fstart", frame_start, 1'b0);
    reset = 1'b0; load_valid = 1'b0;
    step();
    chk("rel_ready", load_ready, 1'b1);
    chk("rel_dvalid", dout_valid, 1'b0);
    $display("txn reset: done");

    // 2: single word 8'h36
    w = 8'h36;
    load_data = w; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("w36_dout%0d", i), dout, w[7-i]);
      chk($sformatf("w36_dv%0d", i), dout_valid, 1'b1);
      chk($sformatf("w36_fs%0d", i), frame_start, (i == 0));
      step();
    end
    chk("w36_end_dout", dout, 1'b1);
    chk("w36_end_dv", dout_valid, 1'b0);
    $display("txn single word 36: done");

    // 3: A5 then 3C back to back
    seq = 16'hA53C;
    load_data = 8'hA5; load_valid = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("str_ready%0d", i), load_ready, (i == 0 || i >= 8));
      chk($sformatf("str_dout%0d", i), dout, seq[15-i]);
      chk($sformatf("str_dv%0d", i), dout_valid, 1'b1);
      chk($sformatf("str_fs%0d", i), frame_start, (i == 0 || i == 8));
      if (i == 0) load_data = 8'h3C;
      if (i == 1) load_valid = 1'b0;
      step();
    end
    chk("str_end_dv", dout_valid, 1'b0);
    $display("txn stream A5,3C: done");

    // 4: second word presented exactly on the last-bit cycle (bypass)
    seq = 16'hC35A;
    load_data = 8'hC3; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("byp_dout%0d", i), dout, seq[15-i]);
      chk($sformatf("byp_dv%0d", i), dout_valid, 1'b1);
      chk($sformatf("byp_fs%0d", i), frame_start, (i == 0 || i == 8));
      if (i == 7) begin
        chk("byp_ready_last", load_ready, 1'b1);
        load_data = 8'h5A; load_valid = 1'b1;
      end else begin
        load_valid = 1'b0;
      end
      step();
    end
    load_valid = 1'b0;
    chk("byp_end_dv", dout_valid, 1'b0);
    $display("txn bypass C3,5A: done");

    // 5: reset mid-word with a word held
    load_data = 8'hF0; load_valid = 1'b1;
    step();
    load_data = 8'h0F;
    step();
    load_valid = 1'b0;
    chk("mid_hold_ready", load_ready, 1'b0);
    step();
    chk("mid_bit3", dout, 1'b1);
    reset = 1'b1;
    step();
    chk("mid_rst_dout", dout, 1'b1);
    chk("mid_rst_dv", dout_valid, 1'b0);
    reset = 1'b0;
    #1;
    chk("mid_rel_ready", load_ready, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("mid_quiet_dv%0d", i), dout_valid, 1'b0);
      chk($sformatf("mid_quiet_dout%0d", i), dout, 1'b1);
    end
    $display("txn reset mid-word: done");

    // 6a: LSB-first, word 8'h01
    load_data2 = 8'h01; load_valid2 = 1'b1;
    step();
    load_valid2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("lsb01_dout%0d", i), dout2, (i == 0));
      chk($sformatf("lsb01_dv%0d", i), dout_valid2, 1'b1);
      step();
    end
    chk("lsb01_end_dv", dout_valid2, 1'b0);
    $display("txn lsb word 01: done");

    // 6b: LSB-first 8'h36 into a 011 detector model, data bits only
    w = 8'h36; hist = 3'b111; pulses = 0;
    load_data2 = w; load_valid2 = 1'b1;
    step();
    load_valid2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("lsb36_dout%0d", i), dout2, w[i]);
      hist = {hist[1:0], dout2};
      if (dout_valid2 && hist == 3'b011) pulses++;
      step();
    end
    chk("lsb36_pulses", pulses, 2);
    $display("txn lsb word 36 detector pulses=%0d", pulses);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
